qerv_rf_host_bridge: RTL and testbench

// - Initiator on the core side of the bit-serial register-file RAM interface (rreq/wreq/ready, W-bit streams).
// - Lets a parallel agent (debug module, init loader, test host) read two registers or write one register with 32-bit words.
// - Owns a full transaction end to end: request pulse, wait for grant, shift 32/W beats, report one parallel response.
// - Sits in place of the core's state/bufreg logic on the RF interface; arbitration against the core is outside this block.

---
 rtl/qerv_rf_host_bridge_pkg.sv | 36 +++
 rtl/qerv_rf_host_shreg.sv | 41 ++++
 rtl/qerv_rf_host_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_qerv_rf_host_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qerv_rf_host_bridge_pkg.sv
// Shared definitions for the register-file host bridge.
// Holds the controller state encoding, the word width and the helpers that
// derive beats-per-word and beat-counter width from the serial width W.
package qerv_rf_host_bridge_pkg;

   localparam int WORD_W = 32;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RREQ   = 3'd1;
   localparam logic [2:0] ST_RWAIT  = 3'd2;
   localparam logic [2:0] ST_RSHIFT = 3'd3;
   localparam logic [2:0] ST_WREQ   = 3'd4;
   localparam logic [2:0] ST_WSHIFT = 3'd5;
   localparam logic [2:0] ST_RESP   = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_RREQ   = ST_RREQ,
      S_RWAIT  = ST_RWAIT,
      S_RSHIFT = ST_RSHIFT,
      S_WREQ   = ST_WREQ,
      S_WSHIFT = ST_WSHIFT,
      S_RESP   = ST_RESP
   } state_t;

   // Number of W-bit beats that make up one 32-bit word.
   function automatic int beats_per_word(input int w);
      return WORD_W / w;
   endfunction

   // Width of a counter that indexes beats 0..N-1 (at least one bit).
   function automatic int beat_cnt_w(input int w);
      return (WORD_W / w > 1) ? $clog2(WORD_W / w) : 1;
   endfunction

endpackage

// File: rtl/qerv_rf_host_shreg.sv
// 32-bit shift register stepping W bits per shift.
// Parallel load / serial out (LSB beat first on o_sout) and serial in /
// parallel out (new beats enter at the top, so after 32/W shifts the first
// beat sits in the least significant bits).
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset (clears contents)
//   i_load/i_ldata parallel load (has priority over shift)
//   i_shift/i_sin  shift one beat, i_sin enters at bits [31:32-W]
//   o_sout         current lowest beat
//   o_q            full register contents
module qerv_rf_host_shreg
   import qerv_rf_host_bridge_pkg::*;
#(
   parameter int W = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic [WORD_W-1:0] i_ldata,
   input  logic              i_shift,
   input  logic [W-1:0]      i_sin,
   output logic [W-1:0]      o_sout,
   output logic [WORD_W-1:0] o_q
);

   logic [WORD_W-1:0] q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         q <= '0;
      end else if (i_load) begin
         q <= i_ldata;
      end else if (i_shift) begin
         q <= {i_sin, q[WORD_W-1:W]};
      end
   end

   assign o_sout = q[W-1:0];
   assign o_q    = q;

endmodule

// File: rtl/qerv_rf_host_bridge.sv
// Host bridge onto the bit-serial register-file interface.
// A parallel agent issues one command at a time: read two registers or write
// one register with a 32-bit word. The bridge raises the request, waits for
// the grant, shifts the W-bit beats and returns a single response pulse.
// Ports:
//   i_clk, i_rst                clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready     command handshake (ready only when idle)
//   i_cmd_we/i_cmd_reg0/1/wdata command: write reg0, or read reg0 and reg1
//   o_rsp_valid/o_rsp_rdata0/1  completion pulse and held read words
//   o_rreq/o_wreq/i_ready       RF request pulses and grant
//   o_rreg0/1, o_wreg0/1        RF register addresses
//   o_wen0/1, o_wdata0/1        RF write enables and write beats
//   i_rdata0/1                  RF read beats
module qerv_rf_host_bridge
   import qerv_rf_host_bridge_pkg::*;
#(
   parameter int W        = 1,
   parameter int csr_regs = 4,
   parameter int raw      = $clog2(32 + csr_regs)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic              i_cmd_we,
   input  logic [raw-1:0]    i_cmd_reg0,
   input  logic [raw-1:0]    i_cmd_reg1,
   input  logic [WORD_W-1:0] i_cmd_wdata,
   output logic              o_rsp_valid,
   output logic [WORD_W-1:0] o_rsp_rdata0,
   output logic [WORD_W-1:0] o_rsp_rdata1,
   output logic              o_rreq,
   output logic              o_wreq,
   input  logic              i_ready,
   output logic [raw-1:0]    o_rreg0,
   output logic [raw-1:0]    o_rreg1,
   output logic [raw-1:0]    o_wreg0,
   output logic [raw-1:0]    o_wreg1,
   output logic              o_wen0,
   output logic              o_wen1,
   output logic [W-1:0]      o_wdata0,
   output logic [W-1:0]      o_wdata1,
   input  logic [W-1:0]      i_rdata0,
   input  logic [W-1:0]      i_rdata1
);

   localparam int N  = beats_per_word(W);
   localparam int CW = beat_cnt_w(W);
   localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q;
   logic [raw-1:0]    reg0_q, reg1_q;
   logic [WORD_W-1:0] rdata0_q, rdata1_q;
   logic              accept;
   logic              cap_shift;
   logic              wd_shift;
   logic              last_beat;
   logic [WORD_W-1:0] cap0_q, cap1_q, wd_q;
   logic [W-1:0]      cap0_sout, cap1_sout;
   logic              unused_bits;

   assign last_beat = (cnt_q == LAST_BEAT);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      o_cmd_ready = 1'b0;
      o_rsp_valid = 1'b0;
      o_rreq      = 1'b0;
      o_wreq      = 1'b0;
      o_wen0      = 1'b0;
      accept      = 1'b0;
      cap_shift   = 1'b0;
      wd_shift    = 1'b0;
      case (state_q)
         S_IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid) begin
               accept  = 1'b1;
               state_d = i_cmd_we ? S_WREQ : S_RREQ;
            end
         end
         S_RREQ: begin
            o_rreq  = 1'b1;
            state_d = S_RWAIT;
         end
         S_RWAIT: begin
            // The grant cycle already carries beat 0.
            if (i_ready) begin
               cap_shift = 1'b1;
               state_d   = S_RSHIFT;
            end
         end
         S_RSHIFT: begin
            cap_shift = 1'b1;
            if (last_beat) begin
               state_d = S_RESP;
            end
         end
         S_WREQ: begin
            o_wreq = 1'b1;
            if (i_ready) begin
               state_d = S_WSHIFT;
            end
         end
         S_WSHIFT: begin
            wd_shift = 1'b1;
            // x0 is hardwired to zero: run the beats but never enable the write.
            o_wen0   = (reg0_q != '0);
            if (last_beat) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            o_rsp_valid = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Beat counter. Entering RSHIFT starts at 1 because beat 0 was taken in
   // the grant cycle; every other state entry clears it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else if (state_d != state_q) begin
         cnt_q <= (state_d == S_RSHIFT) ? CW'(1) : '0;
      end else if (state_q == S_RSHIFT || state_q == S_WSHIFT) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         reg0_q <= '0;
         reg1_q <= '0;
      end else if (accept) begin
         reg0_q <= i_cmd_reg0;
         reg1_q <= i_cmd_reg1;
      end
   end

   // Response words are copied out on the last beat so they stay stable
   // while the capture registers shift during the next read.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (state_q == S_RSHIFT && last_beat) begin
         rdata0_q <= {i_rdata0, cap0_q[WORD_W-1:W]};
         rdata1_q <= {i_rdata1, cap1_q[WORD_W-1:W]};
      end
   end

   qerv_rf_host_shreg #(.W(W)) u_wdata (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (accept & i_cmd_we),
      .i_ldata (i_cmd_wdata),
      .i_shift (wd_shift),
      .i_sin   ({W{1'b0}}),
      .o_sout  (o_wdata0),
      .o_q     (wd_q)
   );

   qerv_rf_host_shreg #(.W(W)) u_cap0 (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (1'b0),
      .i_ldata ({WORD_W{1'b0}}),
      .i_shift (cap_shift),
      .i_sin   (i_rdata0),
      .o_sout  (cap0_sout),
      .o_q     (cap0_q)
   );

   qerv_rf_host_shreg #(.W(W)) u_cap1 (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (1'b0),
      .i_ldata ({WORD_W{1'b0}}),
      .i_shift (cap_shift),
      .i_sin   (i_rdata1),
      .o_sout  (cap1_sout),
      .o_q     (cap1_q)
   );

   assign unused_bits = ^{wd_q, cap0_sout, cap1_sout};

   assign o_rsp_rdata0 = rdata0_q;
   assign o_rsp_rdata1 = rdata1_q;
   assign o_rreg0      = reg0_q;
   assign o_rreg1      = reg1_q;
   assign o_wreg0      = reg0_q;
   assign o_wreg1      = '0;
   assign o_wen1       = 1'b0;
   assign o_wdata1     = '0;

endmodule

// File: tb/tb_qerv_rf_host_bridge.sv
// Self-checking bench for qerv_rf_host_bridge (W=4, 36 registers).
// A behavioural RF responder answers requests; a plain array holds the
// expected register contents.
module tb_qerv_rf_host_bridge;
   localparam int W    = 4;
   localparam int CSR  = 4;
   localparam int RAW  = 6;
   localparam int N    = 32 / W;
   localparam int NREG = 32 + CSR;

   logic            i_clk = 1'b0;
   logic            i_rst;
   logic            i_cmd_valid;
   logic            o_cmd_ready;
   logic            i_cmd_we;
   logic [RAW-1:0]  i_cmd_reg0, i_cmd_reg1;
   logic [31:0]     i_cmd_wdata;
   logic            o_rsp_valid;
   logic [31:0]     o_rsp_rdata0, o_rsp_rdata1;
   logic            o_rreq, o_wreq, i_ready;
   logic [RAW-1:0]  o_rreg0, o_rreg1, o_wreg0, o_wreg1;
   logic            o_wen0, o_wen1;
   logic [W-1:0]    o_wdata0, o_wdata1;
   logic [W-1:0]    rd0, rd1;

   int              n_cmp = 0;
   int              n_bad = 0;
   logic [31:0]     ref_mem [NREG];
   logic [31:0]     rf_mem  [NREG];
   int              grant_delay = 2;
   logic            rd_ready = 1'b0;
   logic [W-1:0]    wlog [$];

   always #5 i_clk = ~i_clk;

   // Writes are granted in the same cycle as the request.
   assign i_ready = rd_ready | o_wreq;

   qerv_rf_host_bridge #(.W(W), .csr_regs(CSR)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_cmd_valid  (i_cmd_valid),
      .o_cmd_ready  (o_cmd_ready),
      .i_cmd_we     (i_cmd_we),
      .i_cmd_reg0   (i_cmd_reg0),
      .i_cmd_reg1   (i_cmd_reg1),
      .i_cmd_wdata  (i_cmd_wdata),
      .o_rsp_valid  (o_rsp_valid),
      .o_rsp_rdata0 (o_rsp_rdata0),
      .o_rsp_rdata1 (o_rsp_rdata1),
      .o_rreq       (o_rreq),
      .o_wreq       (o_wreq),
      .i_ready      (i_ready),
      .o_rreg0      (o_rreg0),
      .o_rreg1      (o_rreg1),
      .o_wreg0      (o_wreg0),
      .o_wreg1      (o_wreg1),
      .o_wen0       (o_wen0),
      .o_wen1       (o_wen1),
      .o_wdata0     (o_wdata0),
      .o_wdata1     (o_wdata1),
      .i_rdata0     (rd0),
      .i_rdata1     (rd1)
   );

   // RF read side: grant grant_delay cycles after rreq, beat 0 in the grant
   // cycle, then one beat per cycle with ready low. Junk otherwise.
   initial begin : rf_read
      logic [31:0] w0, w1;
      rd0 = '0;
      rd1 = '0;
      forever begin
         @(negedge i_clk);
         if (o_rreq) begin
            w0 = rf_mem[o_rreg0];
            w1 = rf_mem[o_rreg1];
            repeat (grant_delay) begin
               rd0 = W'($urandom);
               rd1 = W'($urandom);
               @(negedge i_clk);
            end
            rd_ready = 1'b1;
            for (int k = 0; k < N; k++) begin
               rd0 = w0[W*k +: W];
               rd1 = w1[W*k +: W];
               @(negedge i_clk);
               rd_ready = 1'b0;
            end
         end
         rd0 = W'($urandom);
         rd1 = W'($urandom);
      end
   end

   // RF write side: store enabled beats LSB first.
   initial begin : rf_write
      int wbeat;
      wbeat = 0;
      for (int i = 0; i < NREG; i++) rf_mem[i] = '0;
      forever begin
         @(negedge i_clk);
         if (o_wreq) begin
            wbeat = 0;
         end else if (o_wen0 && wbeat < N && int'(o_wreg0) < NREG) begin
            rf_mem[o_wreg0][W*wbeat +: W] = o_wdata0;
            wbeat++;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one command and follow it to its response, collecting what the
   // RF interface showed along the way.
   task automatic do_cmd(input bit we, input logic [RAW-1:0] r0, input logic [RAW-1:0] r1,
                         input logic [31:0] wd, input int gd,
                         output logic [31:0] g0, output logic [31:0] g1, output int lat,
                         output int idle_w, output int rreq_n, output int wen_n,
                         output int rdy_n, output int both_n, output bit tmo);
      grant_delay = gd;
      wlog.delete();
      lat = 0; idle_w = 0; rreq_n = 0; wen_n = 0; rdy_n = 0; both_n = 0; tmo = 1'b0;
      i_cmd_valid = 1'b1;
      i_cmd_we    = we;
      i_cmd_reg0  = r0;
      i_cmd_reg1  = r1;
      i_cmd_wdata = wd;
      do begin
         @(negedge i_clk);
         idle_w++;
      end while (!o_cmd_ready && idle_w < 100);
      @(posedge i_clk);
      #1;
      i_cmd_valid = 1'b0;
      i_cmd_wdata = $urandom;
      while (lat < 200) begin
         @(negedge i_clk);
         lat++;
         if (o_rreq) rreq_n++;
         if (o_rreq && o_wreq) both_n++;
         if (o_cmd_ready) rdy_n++;
         if (o_wen0) begin
            wen_n++;
            wlog.push_back(o_wdata0);
         end
         if (o_rsp_valid) break;
      end
      tmo = !o_rsp_valid;
      g0  = o_rsp_rdata0;
      g1  = o_rsp_rdata1;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      n_cmp++; if (o_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", o_cmd_ready); end
      n_cmp++; if ({o_rsp_valid, o_rreq, o_wreq, o_wen0} !== 4'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {o_rsp_valid, o_rreq, o_wreq, o_wen0}); end
      n_cmp++; if (o_rsp_rdata0 !== 32'h0) begin n_bad++; $display("FAIL reset_rdata0: got %h want 0", o_rsp_rdata0); end
      n_cmp++; if (o_rsp_rdata1 !== 32'h0) begin n_bad++; $display("FAIL reset_rdata1: got %h want 0", o_rsp_rdata1); end
      n_cmp++; if ({o_wen1, o_wdata1, o_wreg1} !== '0) begin n_bad++; $display("FAIL reset_port1_tied: got %h want 0", {o_wen1, o_wdata1, o_wreg1}); end
   endtask

   task automatic test_read_basic();
      logic [31:0] g0, g1; int lat, iw, rq, wn, rh, bn; bit tmo;
      do_cmd(1'b1, 6'd5, 6'd0, 32'h12345678, 2, g0, g1, lat, iw, rq, wn, rh, bn, tmo);
      ref_mem[5] = 32'h12345678;
      n_cmp++; if (lat !== N + 2) begin n_bad++; $display("FAIL wr_x5_latency: got %0d want %0d", lat, N + 2); end
      do_cmd(1'b1, 6'd10, 6'd0, 32'hDEADBEEF, 2, g0, g1, lat, iw, rq, wn, rh, bn, tmo);
      ref_mem[10] = 32'hDEADBEEF;
      n_cmp++; if (wn !== N) begin n_bad++; $display("FAIL wr_x10_wen_beats: got %0d want %0d", wn, N); end
      do_cmd(1'b0, 6'd5, 6'd10, 32'h0, 2, g0, g1, lat, iw, rq, wn, rh, bn, tmo);
      n_cmp++; if (g0 !== ref_mem[5]) begin n_bad++; $display("FAIL rd_basic_rdata0: got %h want %h", g0, ref_mem[5]); end
      n_cmp++; if (g1 !== ref_mem[10]) begin n_bad++; $display("FAIL rd_basic_rdata1: got %h want %h", g1, ref_mem[10]); end
      // rreq in cycle 1, grant (beat 0) in cycle 1+gd, last beat gd+N, response gd+N+1.
      n_cmp++; if (lat !== 2 + N + 1) begin n_bad++; $display("FAIL rd_basic_latency: got %0d want %0d", lat, 2 + N + 1); end
      n_cmp++; if (rq !== 1) begin n_bad++; $display("FAIL rd_basic_rreq_cycles: got %0d want 1", rq); end
      n_cmp++; if (wn !== 0) begin n_bad++; $display("FAIL rd_basic_no_wen: got %0d want 0", wn); end
   endtask

   task automatic test_write_pattern();
      logic [31:0] g0, g1; int lat, iw, rq, wn, rh, bn; bit tmo;
      logic [31:0] word;
      word = 32'hA5A50F0F;
      do_cmd(1'b1, 6'd7, 6'd3, word, 2, g0, g1, lat, iw, rq, wn, rh, bn, tmo);
      n_cmp++; if (lat !== N + 2) begin n_bad++; $display("FAIL wr_pat_latency: got %0d want %0d", lat, N + 2); end
      n_cmp++; if (wlog.size() !== N) begin n_bad++; $display("FAIL wr_pat_beats: got %0d want %0d", wlog.size(), N); end
      for (int k = 0; k < N && k < wlog.size(); k++) begin
         n_cmp++;
         if (wlog[k] !== W'((word >> (W * k)) & 32'hF)) begin
            n_bad++; $display("FAIL wr_pat_beat%0d: got %h want %h", k, wlog[k], W'((word >> (W * k)) & 32'hF));
         end
      end
      n_cmp++; if (rq !== 0) begin n_bad++; $display("FAIL wr_pat_no_rreq: got %0d want 0", rq); end
      // A write must leave the previous read words untouched.
      n_cmp++; if (g0 !== ref_mem[5]) begin n_bad++; $display("FAIL wr_pat_rdata_held: got %h want %h", g0, ref_mem[5]); end
      ref_mem[7] = word;
      do_cmd(1'b0, 6'd7, 6'd5, 32'h0, 3, g0, g1, lat, iw, rq, wn, rh, bn, tmo);
      n_cmp++; if (g0 !== word) begin n_bad++; $display("FAIL wr_pat_readback: got %h want %h", g0, word); end
   endtask

   task automatic test_write_x0();
      logic [31:0] g0, g1; int lat, iw, rq, wn, rh, bn; bit tmo;
      do_cmd(1'b1, 6'd0, 6'd0, 32'hFFFFFFFF, 2, g0, g1, lat, iw, rq, wn, rh, bn, tmo);
      n_cmp++; if (wn !== 0) begin n_bad++; $display("FAIL wr_x0_wen: got %0d want 0", wn); end
      n_cmp++; if (tmo !== 1'b0 || lat !== N + 2) begin n_bad++; $display("FAIL wr_x0_rsp: got lat %0d tmo %b want lat %0d", lat, tmo, N + 2); end
      do_cmd(1'b0, 6'd0, 6'd7, 32'h0, 2, g0, g1, lat, iw, rq, wn, rh, bn, tmo);
      n_cmp++; if (g0 !== 32'h0) begin n_bad++; $display("FAIL rd_x0: got %h want 0", g0); end
      n_cmp++; if (g1 !== ref_mem[7]) begin n_bad++; $display("FAIL rd_x0_port1: got %h want %h", g1, ref_mem[7]); end
   endtask

   task automatic test_grant_delay();
      logic [31:0] g0, g1; int lat, iw, rq, wn, rh, bn; bit tmo;
      do_cmd(1'b0, 6'd10, 6'd5, 32'h0, 7, g0, g1, lat, iw, rq, wn, rh, bn, tmo);
      n_cmp++; if (g0 !== ref_mem[10]) begin n_bad++; $display("FAIL gd7_rdata0: got %h want %h", g0, ref_mem[10]); end
      n_cmp++; if (g1 !== ref_mem[5]) begin n_bad++; $display("FAIL gd7_rdata1: got %h want %h", g1, ref_mem[5]); end
      n_cmp++; if (rq !== 1) begin n_bad++; $display("FAIL gd7_rreq_cycles: got %0d want 1", rq); end
      n_cmp++; if (lat !== 7 + N + 1) begin n_bad++; $display("FAIL gd7_latency: got %0d want %0d", lat, 7 + N + 1); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] g0, g1; int lat, iw, rq, wn, rh, bn; bit tmo;
      int pulses;
      grant_delay = 3;
      i_cmd_valid = 1'b1; i_cmd_we = 1'b0; i_cmd_reg0 = 6'd5; i_cmd_reg1 = 6'd10;
      iw = 0;
      do begin @(negedge i_clk); iw++; end while (!o_cmd_ready && iw < 50);
      @(posedge i_clk);
      #1;
      i_cmd_valid = 1'b0;
      // rreq in cycle 1, beat 0 in cycle 4, beat 5 in cycle 9.
      repeat (9) @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      n_cmp++; if ({o_rsp_valid, o_rreq, o_wreq, o_wen0} !== 4'b0) begin n_bad++; $display("FAIL midrst_ctrl: got %b want 0000", {o_rsp_valid, o_rreq, o_wreq, o_wen0}); end
      n_cmp++; if (o_rsp_rdata0 !== 32'h0 || o_rsp_rdata1 !== 32'h0) begin n_bad++; $display("FAIL midrst_rdata: got %h %h want 0 0", o_rsp_rdata0, o_rsp_rdata1); end
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      pulses = 0;
      repeat (15) begin
         @(negedge i_clk);
         if (o_rsp_valid) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midrst_no_rsp: got %0d pulses want 0", pulses); end
      do_cmd(1'b0, 6'd5, 6'd10, 32'h0, 3, g0, g1, lat, iw, rq, wn, rh, bn, tmo);
      n_cmp++; if (g0 !== ref_mem[5] || g1 !== ref_mem[10]) begin n_bad++; $display("FAIL midrst_next_read: got %h %h want %h %h", g0, g1, ref_mem[5], ref_mem[10]); end
      n_cmp++; if (lat !== 3 + N + 1) begin n_bad++; $display("FAIL midrst_next_latency: got %0d want %0d", lat, 3 + N + 1); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] g0, g1; int lat, iw, rq, wn, rh, bn; bit tmo;
      logic [31:0] word;
      word = $urandom;
      do_cmd(1'b1, 6'd33, 6'd0, word, 2, g0, g1, lat, iw, rq, wn, rh, bn, tmo);
      ref_mem[33] = word;
      n_cmp++; if (rh !== 0) begin n_bad++; $display("FAIL b2b_wr_cmd_ready: got %0d high cycles want 0", rh); end
      do_cmd(1'b0, 6'd33, 6'd5, 32'h0, 2, g0, g1, lat, iw, rq, wn, rh, bn, tmo);
      n_cmp++; if (iw !== 1) begin n_bad++; $display("FAIL b2b_accept_gap: got %0d want 1", iw); end
      n_cmp++; if (rh !== 0) begin n_bad++; $display("FAIL b2b_rd_cmd_ready: got %0d high cycles want 0", rh); end
      n_cmp++; if (g0 !== word) begin n_bad++; $display("FAIL b2b_csr33: got %h want %h", g0, word); end
   endtask

   task automatic test_random();
      logic [31:0] g0, g1; int lat, iw, rq, wn, rh, bn; bit tmo;
      logic [31:0] word;
      logic [RAW-1:0] r0, r1;
      bit we;
      int gd;
      for (int t = 0; t < 24; t++) begin
         we   = ($urandom_range(0, 1) == 1);
         r0   = RAW'($urandom_range(0, NREG - 1));
         r1   = RAW'($urandom_range(0, NREG - 1));
         word = $urandom;
         gd   = $urandom_range(2, 6);
         do_cmd(we, r0, r1, word, gd, g0, g1, lat, iw, rq, wn, rh, bn, tmo);
         n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_timeout: no response within bound", t); end
         n_cmp++; if (bn !== 0 || rh !== 0) begin n_bad++; $display("FAIL rnd%0d_protocol: got overlap %0d ready %0d want 0 0", t, bn, rh); end
         if (we) begin
            if (r0 != 0) ref_mem[r0] = word;
            n_cmp++; if (lat !== N + 2 || wn !== ((r0 != 0) ? N : 0)) begin
               n_bad++; $display("FAIL rnd%0d_write: got lat %0d wen %0d want lat %0d wen %0d", t, lat, wn, N + 2, (r0 != 0) ? N : 0);
            end
         end else begin
            n_cmp++; if (g0 !== ref_mem[r0] || g1 !== ref_mem[r1]) begin
               n_bad++; $display("FAIL rnd%0d_read: got %h %h want %h %h", t, g0, g1, ref_mem[r0], ref_mem[r1]);
            end
            n_cmp++; if (lat !== gd + N + 1 || rq !== 1) begin
               n_bad++; $display("FAIL rnd%0d_read_timing: got lat %0d rreq %0d want lat %0d rreq 1", t, lat, rq, gd + N + 1);
            end
         end
      end
   endtask

   initial begin
      i_rst       = 1'b1;
      i_cmd_valid = 1'b0;
      i_cmd_we    = 1'b0;
      i_cmd_reg0  = '0;
      i_cmd_reg1  = '0;
      i_cmd_wdata = '0;
      for (int i = 0; i < NREG; i++) ref_mem[i] = '0;
      test_reset();
      test_read_basic();
      test_write_pattern();
      test_write_x0();
      test_grant_delay();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
